// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_pkg : shared types and constants for the PS/2 scan-code receiver  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

    // Odd parity: data bits plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic parity_bit);
        return ^{data_byte, parity_bit};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_scancode_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_scancode_ctrl_if : keyboard pins and decoded key-event bus        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ps2_scancode_ctrl_if;
    logic       ps2clk;
    logic       ps2data;
    logic [7:0] code;
    logic       code_valid;
    logic       is_break;
    logic       is_ext;
    logic       frame_err;
    logic       busy;

    // master: the receiver that decodes pins into events
    modport master (
        input  ps2clk, ps2data,
        output code, code_valid, is_break, is_ext, frame_err, busy
    );

    // slave: the pin driver / event consumer side
    modport slave (
        output ps2clk, ps2data,
        input  code, code_valid, is_break, is_ext, frame_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_sync_edge : 2-flop synchronizers and registered ps2clk fall strobe |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic ps2clk,
    input  logic ps2data,
    output logic data_sync,
    output logic fall
);
    // [0],[1] are the synchronizer stages, [2] holds the previous synchronized value
    logic [2:0] clk_pipe_q,  clk_pipe_d;
    logic [2:0] data_pipe_q, data_pipe_d;
    logic       fall_q,      fall_d;

    always_comb begin
        clk_pipe_d  = {clk_pipe_q[1:0], ps2clk};
        data_pipe_d = {data_pipe_q[1:0], ps2data};
        fall_d      = clk_pipe_q[2] & ~clk_pipe_q[1];
    end

    // Idle PS/2 lines are high; resetting to 1 avoids a spurious fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_pipe_q  <= 3'b111;
            data_pipe_q <= 3'b111;
            fall_q      <= 1'b0;
        end else begin
            clk_pipe_q  <= clk_pipe_d;
            data_pipe_q <= data_pipe_d;
            fall_q      <= fall_d;
        end
    end

    assign data_sync = data_pipe_q[2];
    assign fall      = fall_q;
endmodule
`default_nettype wire

// File: rtl/ps2_scancode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_scancode_ctrl : PS/2 frame FSM, watchdog and E0/F0 prefix folding |
// | Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_scancode_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                clk,
    input  logic                rst,
    ps2_scancode_ctrl_if.master bus
);
    localparam int             WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic data;
    logic fall;

    ps2_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .ps2clk    (bus.ps2clk),
        .ps2data   (bus.ps2data),
        .data_sync (data),
        .fall      (fall)
    );

    ps2_state_t      state_q,      state_d;
    logic [2:0]      bit_cnt_q,    bit_cnt_d;
    logic [7:0]      shift_q,      shift_d;
    logic            par_ok_q,     par_ok_d;
    logic [WD_W-1:0] wd_q,         wd_d;
    logic            pend_ext_q,   pend_ext_d;
    logic            pend_break_q, pend_break_d;
    logic [7:0]      code_q,       code_d;
    logic            code_valid_q, code_valid_d;
    logic            is_break_q,   is_break_d;
    logic            is_ext_q,     is_ext_d;
    logic            frame_err_q,  frame_err_d;
    logic            busy_q,       busy_d;
    logic            byte_ok;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        wd_d         = wd_q;
        pend_ext_d   = pend_ext_q;
        pend_break_d = pend_break_q;
        code_d       = code_q;
        is_break_d   = is_break_q;
        is_ext_d     = is_ext_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        byte_ok      = 1'b0;

        if (fall) begin
            wd_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!data) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d   = {data, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_ok_d = odd_parity_ok(shift_q, data);
`else
                    par_ok_d = 1'b1;
`endif
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data && par_ok_q) byte_ok     = 1'b1;
                    else                  frame_err_d = 1'b1;
                end
            endcase
        end else if (state_q != IDLE) begin
            // Stalled frame: abandon the partial byte once the gap exceeds the limit.
            if (wd_q == WD_LAST) begin
                state_d     = IDLE;
                frame_err_d = 1'b1;
                wd_d        = '0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end else begin
            wd_d = '0;
        end

        if (frame_err_d) begin
            pend_ext_d   = 1'b0;
            pend_break_d = 1'b0;
        end else if (byte_ok) begin
            if (shift_q == PS2_EXT) begin
                pend_ext_d = 1'b1;
            end else if (shift_q == PS2_BREAK) begin
                pend_break_d = 1'b1;
            end else begin
                code_d       = shift_q;
                is_ext_d     = pend_ext_q;
                is_break_d   = pend_break_q;
                code_valid_d = 1'b1;
                pend_ext_d   = 1'b0;
                pend_break_d = 1'b0;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_ok_q     <= 1'b0;
            wd_q         <= '0;
            pend_ext_q   <= 1'b0;
            pend_break_q <= 1'b0;
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
            is_break_q   <= 1'b0;
            is_ext_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            wd_q         <= wd_d;
            pend_ext_q   <= pend_ext_d;
            pend_break_q <= pend_break_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            is_break_q   <= is_break_d;
            is_ext_q     <= is_ext_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.code       = code_q;
    assign bus.code_valid = code_valid_q;
    assign bus.is_break   = is_break_q;
    assign bus.is_ext     = is_ext_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;
endmodule
`default_nettype wire
